// File: rtl/bmem_arbiter_if.sv
// Cache-side and burst-memory-side signals of bmem_arbiter.
// slave: the arbiter's view; master: the caches and memory that drive it.
interface bmem_arbiter_if;
    logic [31:0]  i_addr;
    logic         i_read;
    logic [255:0] i_rdata;
    logic         i_resp;

    logic [31:0]  d_addr;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;

    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    modport slave (
        input  i_addr, i_read,
        output i_rdata, i_resp,
        input  d_addr, d_read, d_write, d_wdata,
        output d_rdata, d_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    modport master (
        output i_addr, i_read,
        input  i_rdata, i_resp,
        output d_addr, d_read, d_write, d_wdata,
        input  d_rdata, d_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );
endinterface

// File: rtl/bmem_arbiter.sv
// Shares one 4-beat burst memory between I-cache and D-cache, one transaction at a time.
// Define BMEM_ARB_DCACHE_PRIORITY_EN to let the D-cache win every tie instead of round-robin.
//
// state    | meaning
// IDLE     | sample requests, grant one, latch port/address/wdata
// RD_ISSUE | hold bmem_read until the memory accepts it
// RD_WAIT  | collect four beats whose raddr matches the issued line
// WR_BURST | stream four write beats, advancing on bmem_ready
// RESP     | one-cycle resp pulse to the granted port
module bmem_arbiter (
    input  logic          clk,
    input  logic          rst,
    bmem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_BURST, RESP} state_t;

    state_t       state;
    logic [1:0]   cnt;
    logic [1:0]   cnt_nx;
    logic         gnt_d;
    logic [255:0] wdata_q;
    logic [191:0] line_q;
    logic         i_req;
    logic         d_req;
    logic         pick_d;

    assign i_req  = bus.i_read;
    assign d_req  = bus.d_read | bus.d_write;
    assign cnt_nx = cnt + 2'd1;

`ifdef BMEM_ARB_DCACHE_PRIORITY_EN
    assign pick_d = d_req;
`else
    logic last_d;
    assign pick_d = d_req & (~i_req | ~last_d);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 2'd0;
            gnt_d          <= 1'b0;
            wdata_q        <= '0;
            line_q         <= '0;
            bus.bmem_addr  <= '0;
            bus.bmem_read  <= 1'b0;
            bus.bmem_write <= 1'b0;
            bus.bmem_wdata <= '0;
            bus.i_resp     <= 1'b0;
            bus.d_resp     <= 1'b0;
            bus.i_rdata    <= '0;
            bus.d_rdata    <= '0;
`ifndef BMEM_ARB_DCACHE_PRIORITY_EN
            last_d         <= 1'b1;
`endif
        end else begin
            bus.i_resp <= 1'b0;
            bus.d_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        gnt_d         <= pick_d;
                        bus.bmem_addr <= (pick_d ? bus.d_addr : bus.i_addr) & ~32'h1F;
                        wdata_q       <= bus.d_wdata;
                        cnt           <= 2'd0;
`ifndef BMEM_ARB_DCACHE_PRIORITY_EN
                        last_d        <= pick_d;
`endif
                        // A simultaneous d_read/d_write is treated as a write.
                        if (pick_d && bus.d_write) begin
                            bus.bmem_write <= 1'b1;
                            bus.bmem_wdata <= bus.d_wdata[63:0];
                            state          <= WR_BURST;
                        end else begin
                            bus.bmem_read <= 1'b1;
                            state         <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (bus.bmem_ready) begin
                        bus.bmem_read <= 1'b0;
                        state         <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (bus.bmem_rvalid && (bus.bmem_raddr == bus.bmem_addr)) begin
                        cnt <= cnt_nx;
                        case (cnt)
                            2'd0: line_q[63:0]    <= bus.bmem_rdata;
                            2'd1: line_q[127:64]  <= bus.bmem_rdata;
                            2'd2: line_q[191:128] <= bus.bmem_rdata;
                            default: begin
                                if (gnt_d) begin
                                    bus.d_rdata <= {bus.bmem_rdata, line_q};
                                    bus.d_resp  <= 1'b1;
                                end else begin
                                    bus.i_rdata <= {bus.bmem_rdata, line_q};
                                    bus.i_resp  <= 1'b1;
                                end
                                state <= RESP;
                            end
                        endcase
                    end
                end
                WR_BURST: begin
                    if (bus.bmem_ready) begin
                        cnt <= cnt_nx;
                        if (cnt == 2'd3) begin
                            bus.bmem_write <= 1'b0;
                            bus.d_resp     <= 1'b1;
                            state          <= RESP;
                        end else begin
                            bus.bmem_wdata <= wdata_q[{cnt_nx, 6'b0} +: 64];
                        end
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bmem_arbiter.sv
// Randomized and directed bench for bmem_arbiter against a transaction-level memory model.
// Honours BMEM_ARB_DCACHE_PRIORITY_EN for the tie-break expectations.
module tb_bmem_arbiter;
    typedef struct {
        bit           port;   // 0 = I-cache, 1 = D-cache
        bit           is_wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } txn_t;

    logic clk;
    logic rst;
    bmem_arbiter_if bus ();

    bmem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [255:0] mem [logic [31:0]];
    txn_t         exp_q [$];
    logic [63:0]  wacc [$];
    logic [63:0]  last_wbeats [$];
    logic [255:0] exp_i_line, exp_d_line;
    bit           last_d;
    int           done_i = 0, done_d = 0;
    int           rd_cycles = 0, resp_cyc = 0, last_wacc_cyc = 0, req_cyc = 0;
    int           order_val = 0;
    logic [31:0]  seen_rd_addr;

    bit           rdy_pat [$];
    bit           rdy_rand = 0, stray_en = 0, inject_ffe0 = 0, inject_idle = 0;
    logic [31:0]  stray_addr = 0, last_rd_addr = 0, rd_addr = 0;
    bit           rd_busy = 0;
    int           rd_beat = 0, rd_wait = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a ^ 32'hA5A5_0003, a, a ^ 32'h5A5A_0002, a, a ^ 32'h3C3C_0001, a, a ^ 32'hC3C3_0000, a};
    endfunction

    // Burst memory: ready generation, read-beat return, stray beats.
    initial begin
        logic [255:0] line;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.bmem_ready  = 1'b0;
                bus.bmem_rvalid = 1'b0;
                rd_busy         = 0;
            end else begin
                if (rdy_pat.size() > 0 && (bus.bmem_read || bus.bmem_write))
                    bus.bmem_ready = rdy_pat.pop_front();
                else if (rdy_rand)
                    bus.bmem_ready = ($urandom_range(0, 3) != 0);
                else
                    bus.bmem_ready = 1'b1;
                bus.bmem_rvalid = 1'b0;
                bus.bmem_raddr  = 32'h0;
                bus.bmem_rdata  = {$urandom, $urandom};
                if (rd_busy) begin
                    if (inject_ffe0 && rd_wait == 0) begin
                        bus.bmem_rvalid = 1'b1;
                        bus.bmem_raddr  = 32'h0000_FFE0;
                        inject_ffe0     = 0;
                    end else if (stray_en && $urandom_range(0, 4) == 0) begin
                        bus.bmem_rvalid = 1'b1;
                        bus.bmem_raddr  = rd_addr ^ 32'h20;
                    end else if (rd_wait > 0) begin
                        rd_wait--;
                    end else begin
                        line            = mem_line(rd_addr);
                        bus.bmem_rvalid = 1'b1;
                        bus.bmem_raddr  = rd_addr;
                        bus.bmem_rdata  = line[64*rd_beat +: 64];
                        rd_beat++;
                        if (rd_beat == 4) rd_busy = 0;
                    end
                end else if (inject_idle) begin
                    bus.bmem_rvalid = 1'b1;
                    bus.bmem_raddr  = stray_addr;
                    inject_idle     = 0;
                end else if (stray_en && $urandom_range(0, 5) == 0) begin
                    bus.bmem_rvalid = 1'b1;
                    bus.bmem_raddr  = last_rd_addr;
                end
                if (bus.bmem_read && bus.bmem_ready && !rd_busy) begin
                    rd_busy      = 1;
                    rd_addr      = bus.bmem_addr;
                    last_rd_addr = bus.bmem_addr;
                    rd_beat      = 0;
                    rd_wait      = rdy_rand ? $urandom_range(0, 3) : 0;
                end
            end
        end
    end

    // Compare process: every cycle, DUT outputs against the transaction model.
    initial begin
        txn_t h;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                exp_i_line = '0;
                exp_d_line = '0;
                chk("rst_ctrl", {bus.bmem_read, bus.bmem_write, bus.i_resp, bus.d_resp, bus.bmem_addr, bus.bmem_wdata}, '0);
                chk("rst_i_rdata", bus.i_rdata, '0);
                chk("rst_d_rdata", bus.d_rdata, '0);
            end else begin
                chk("resp_exclusive", bus.i_resp & bus.d_resp, 0);
                chk("rd_wr_exclusive", bus.bmem_read & bus.bmem_write, 0);
                if (bus.bmem_read) begin
                    rd_cycles++;
                    seen_rd_addr = bus.bmem_addr;
                end
                if (bus.bmem_read || bus.bmem_write) begin
                    if (exp_q.size() == 0) begin
                        chk("bus_active_while_idle", {bus.bmem_read, bus.bmem_write}, 0);
                    end else begin
                        h = exp_q[0];
                        chk("bmem_addr", bus.bmem_addr, h.addr);
                        chk("bmem_dir_write", bus.bmem_write, h.is_wr);
                        if (bus.bmem_write && bus.bmem_ready) begin
                            if (wacc.size() < 4)
                                chk("wr_beat_data", bus.bmem_wdata, h.wdata[64*wacc.size() +: 64]);
                            wacc.push_back(bus.bmem_wdata);
                            last_wacc_cyc = cyc;
                        end
                    end
                end
                if (bus.i_resp || bus.d_resp) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_resp", {bus.i_resp, bus.d_resp}, 0);
                    end else begin
                        h = exp_q.pop_front();
                        chk("resp_port", bus.d_resp, h.port);
                        if (h.is_wr) begin
                            chk("wr_beat_count", wacc.size(), 4);
                            mem[h.addr] = h.wdata;
                        end else if (h.port) begin
                            exp_d_line = mem_line(h.addr);
                        end else begin
                            exp_i_line = mem_line(h.addr);
                        end
                        last_wbeats = wacc;
                        wacc.delete();
                        resp_cyc  = cyc;
                        order_val = (order_val << 1) | int'(h.port);
                        if (h.port) done_d++;
                        else        done_i++;
                    end
                end
                chk("i_rdata", bus.i_rdata, exp_i_line);
                chk("d_rdata", bus.d_rdata, exp_d_line);
            end
        end
    end

    task automatic run_txn(input bit ui, input bit ud, input logic [31:0] ia, input logic [31:0] da,
                           input bit dr, input bit dw, input logic [255:0] wd);
        txn_t ti, td;
        bit   d_first;
        int   bi, bd, budget;
        ti.port = 0; ti.is_wr = 0;  ti.addr = ia & ~32'h1F; ti.wdata = '0;
        td.port = 1; td.is_wr = dw; td.addr = da & ~32'h1F; td.wdata = wd;
        if (ui && ud) begin
`ifdef BMEM_ARB_DCACHE_PRIORITY_EN
            d_first = 1;
`else
            d_first = !last_d;
`endif
            if (d_first) begin exp_q.push_back(td); exp_q.push_back(ti); last_d = 0; end
            else         begin exp_q.push_back(ti); exp_q.push_back(td); last_d = 1; end
        end else if (ui) begin
            exp_q.push_back(ti); last_d = 0;
        end else begin
            exp_q.push_back(td); last_d = 1;
        end
        bi = done_i;
        bd = done_d;
        @(posedge clk); #2;
        req_cyc     = cyc;
        bus.i_addr  = ia;
        bus.d_addr  = da;
        bus.d_wdata = wd;
        bus.i_read  = ui;
        bus.d_read  = ud & dr;
        bus.d_write = ud & dw;
        budget = 0;
        while ((bus.i_read || bus.d_read || bus.d_write) && budget < 300) begin
            @(posedge clk); #2;
            budget++;
            if (done_i != bi) bus.i_read = 0;
            if (done_d != bd) begin bus.d_read = 0; bus.d_write = 0; end
        end
        chk("txn_completes_in_budget", budget < 300, 1);
        bus.i_read  = 0;
        bus.d_read  = 0;
        bus.d_write = 0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #2;
        rst = 1;
        exp_q.delete();
        wacc.delete();
        bus.i_read = 0; bus.d_read = 0; bus.d_write = 0;
        last_d = 1;
        repeat (3) @(posedge clk);
        #2 rst = 0;
    endtask

    initial begin
        logic [255:0] wd;
        int bi, bd, budget;
        rst = 1;
        last_d = 1;
        bus.i_addr = 0; bus.i_read = 0;
        bus.d_addr = 0; bus.d_read = 0; bus.d_write = 0; bus.d_wdata = '0;
        bus.bmem_ready = 0; bus.bmem_raddr = 0; bus.bmem_rdata = 0; bus.bmem_rvalid = 0;
        repeat (3) @(posedge clk);
        #2 rst = 0;

        // I-cache read of a known line.
        mem[32'h1ECE_B000] = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
        rd_cycles = 0;
        bi = done_i;
        run_txn(1, 0, 32'h1ECE_B004, 0, 0, 0, '0);
        repeat (3) @(posedge clk);
        chk("req024_read_cycles", rd_cycles, 1);
        chk("req024_addr", seen_rd_addr, 32'h1ECE_B000);
        chk("req024_resp_count", done_i - bi, 1);
        chk("req024_line", bus.i_rdata, {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}});

        // D-cache write with ready toggling 1,0,1,1,0,1.
        rdy_pat = '{1, 0, 1, 1, 0, 1};
        wd = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002, 64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
        run_txn(0, 1, 0, 32'h0000_1020, 0, 1, wd);
        chk("req025_beats", last_wbeats.size(), 4);
        if (last_wbeats.size() == 4) begin
            chk("req025_beat0", last_wbeats[0], 64'hD0D0_0000_0000_0000);
            chk("req025_beat3", last_wbeats[3], 64'hD3D3_0000_0000_0003);
        end
        chk("req025_resp_gap", resp_cyc - last_wacc_cyc, 1);

        // d_read and d_write together: a write burst, no read issue.
        rd_cycles = 0;
        run_txn(0, 1, 0, 32'h0000_1040, 1, 1, ~wd);
        chk("req029_no_read", rd_cycles, 0);
        chk("req029_beats", last_wbeats.size(), 4);
        chk("req029_latency", resp_cyc - req_cyc, 5);

        // Stray beats: one in IDLE on the target line, one mismatched during RD_WAIT.
        mem[32'h0000_2000] = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                              64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
        stray_addr  = 32'h0000_2000;
        inject_idle = 1;
        repeat (3) @(posedge clk);
        inject_ffe0 = 1;
        run_txn(0, 1, 0, 32'h0000_2010, 1, 0, '0);
        chk("req027_line", bus.d_rdata, {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                                         64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101});

        // Tie-break order from reset, three rounds of simultaneous reads.
        apply_reset();
        order_val = 0;
        for (int k = 0; k < 3; k++)
            run_txn(1, 1, 32'h0000_5000 + 32'(k) * 32'h40, 32'h0000_6000 + 32'(k) * 32'h40, 1, 0, '0);
`ifdef BMEM_ARB_DCACHE_PRIORITY_EN
        chk("req026_order", order_val, 6'b101010);
`else
        chk("req026_order", order_val, 6'b010101);
`endif

        // Reset after beat 2 of a write.
        wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        begin
            txn_t t;
            t.port = 1; t.is_wr = 1; t.addr = 32'h0000_3000; t.wdata = wd;
            exp_q.push_back(t);
        end
        bd = done_d;
        @(posedge clk); #2;
        bus.d_addr = 32'h0000_3000; bus.d_wdata = wd; bus.d_write = 1;
        budget = 0;
        while (wacc.size() < 2 && budget < 50) begin
            @(posedge clk); #2;
            budget++;
        end
        chk("req028_reached_beat2", budget < 50, 1);
        chk("req028_write_before_rst", bus.bmem_write, 1);
        #1;
        rst = 1;
        exp_q.delete();
        wacc.delete();
        bus.d_write = 0;
        last_d = 1;
        #1;
        chk("req028_async_write_drop", bus.bmem_write, 0);
        chk("req028_async_addr_zero", bus.bmem_addr, 0);
        repeat (3) @(posedge clk);
        #2 rst = 0;
        repeat (4) @(posedge clk);
        chk("req028_no_dresp", done_d - bd, 0);
        bd = done_d;
        run_txn(0, 1, 0, 32'h0000_3000, 0, 1, wd);
        run_txn(1, 0, 32'h0000_3008, 0, 0, 0, '0);
        chk("req028_next_served", done_d - bd, 1);
        chk("req028_readback", bus.i_rdata, wd);

        // Randomized traffic with random ready, latency and stray beats.
        rdy_rand = 1;
        stray_en = 1;
        for (int k = 0; k < 60; k++) begin
            int p, dk;
            logic [31:0] ia, da;
            p  = $urandom_range(0, 2);
            dk = $urandom_range(0, 2);
            ia = 32'h0000_4000 + ($urandom_range(0, 7) << 5) + $urandom_range(0, 31);
            da = 32'h0000_4000 + ($urandom_range(0, 7) << 5) + $urandom_range(0, 31);
            wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_txn(p != 2, p != 1, ia, da, dk != 1, dk != 0, wd);
        end
        repeat (5) @(posedge clk);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
